apb_master_bridge: RTL and testbench

//  APB requester (initiator) converting a simple valid/ready command port into APB

---
 rtl/apb_master_bridge.sv | 160 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : Converts a valid/ready command port into single APB transfers,
//            with a held response port and an ACCESS-phase timeout.
// Revision : 1.0
// ============================================================================
module apb_master_bridge #(
    parameter int AWIDTH  = 4,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_tmo,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int                c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic                psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic                pwrite_q,    pwrite_d;
    logic [AWIDTH-1:0]   paddr_q,     paddr_d;
    logic [DWIDTH-1:0]   pwdata_q,    pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;
    logic                rsp_tmo_q,   rsp_tmo_d;
    logic [c_CNT_W-1:0]  wait_cnt_q,  wait_cnt_d;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d   = S_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                end
            end
            S_SETUP: begin
                state_d    = S_ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    state_d     = S_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    rsp_tmo_d   = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + c_CNT_W'(1);
                    // Counter still holds the previous stall count, so the last
                    // permitted stall is the one where it reads TIMEOUT-1.
                    if (wait_cnt_q == c_TMO_LAST) begin
                        state_d     = S_RESP;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_tmo_d   = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_tmo   = rsp_tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Purpose  : Scoreboard bench for apb_master_bridge with an APB slave model.
// Revision : 1.0
// ============================================================================
module tb_apb_master_bridge;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int TMO = 15;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, rsp_tmo;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    apb_master_bridge #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;   // PREADY=0 cycles the slave inserts
        logic [DW-1:0] prdata;
        logic          slverr;
    } txn_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int            first_cyc;
    } rsp_t;

    txn_t bus_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic rdy_low = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int n_access(input txn_t t);
        return (t.waits >= TMO) ? TMO : t.waits + 1;
    endfunction

    function automatic rsp_t model(input txn_t t, input int accept_cyc);
        rsp_t r;
        if (t.waits >= TMO) begin
            r.rdata = '0; r.err = 1'b1; r.tmo = 1'b1;
        end else begin
            r.rdata = t.wr ? '0 : t.prdata;
            r.err   = t.slverr;
            r.tmo   = 1'b0;
        end
        r.first_cyc = accept_cyc + 1 + n_access(t);
        return r;
    endfunction

    function automatic txn_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input int waits, input logic [DW-1:0] prd, input logic err);
        txn_t t;
        t.wr = wr; t.addr = a; t.wdata = wd; t.waits = waits; t.prdata = prd; t.slverr = err;
        return t;
    endfunction

    // Command driver: scrambles cmd_* while the bridge is busy
    task automatic issue(input txn_t t);
        int g = 0;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        forever begin
            if (cmd_ready) begin
                cmd_write = t.wr; cmd_addr = t.addr; cmd_wdata = t.wdata;
                break;
            end
            cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
            if (g > 500) break;
            @(negedge PCLK);
            g++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
        end else begin
            bus_q.push_back(t);
            rsp_q.push_back(model(t, cyc + 1));
        end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    endtask

    task automatic drain();
        int g = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && g < 1000) begin
            @(negedge PCLK);
            g++;
        end
        check("drain_outstanding", 32'(rsp_q.size()), 32'd0);
    endtask

    always begin
        @(posedge PCLK);
        #1 rsp_ready = rdy_low ? 1'b0 : ($urandom_range(0, 9) < 7);
    end

    // APB slave model and bus-side protocol checks
    txn_t cur;
    int   acc_n = 0;
    always @(negedge PCLK) begin
        if (PRESET) begin
            acc_n  = 0;
            PREADY = 1'b0;
        end else if (PSEL && !PENABLE) begin
            check("psel_gap_before_setup", 32'(acc_n), 32'd0);
            if (bus_q.size() == 0) begin
                check("unexpected_setup", 32'd1, 32'd0);
            end else begin
                cur = bus_q[0];
                check("setup_paddr", 32'(PADDR), 32'(cur.addr));
                check("setup_pwrite", 32'(PWRITE), 32'(cur.wr));
                check("setup_pwdata", 32'(PWDATA), cur.wr ? 32'(cur.wdata) : 32'd0);
            end
            acc_n   = 0;
            PREADY  = 1'($urandom);
            PRDATA  = DW'($urandom);
            PSLVERR = 1'($urandom);
        end else if (PSEL && PENABLE) begin
            acc_n++;
            check("access_paddr", 32'(PADDR), 32'(cur.addr));
            check("access_pwdata", 32'(PWDATA), cur.wr ? 32'(cur.wdata) : 32'd0);
            PREADY  = (acc_n == cur.waits + 1);
            PRDATA  = (PREADY && !cur.wr) ? cur.prdata : DW'($urandom);
            PSLVERR = PREADY ? cur.slverr : 1'($urandom);
        end else begin
            check("penable_without_psel", 32'(PENABLE), 32'd0);
            if (acc_n != 0) begin
                check("access_cycles", 32'(acc_n), 32'(n_access(cur)));
                if (bus_q.size() != 0) void'(bus_q.pop_front());
                acc_n = 0;
            end
            PREADY  = 1'($urandom);
            PRDATA  = DW'($urandom);
            PSLVERR = 1'($urandom);
        end
    end

    // Response monitor / scoreboard
    logic       rv_prev = 1'b0;
    logic       hs_prev = 1'b0;
    logic [9:0] snap;
    rsp_t       e;
    always @(negedge PCLK) begin
        if (PRESET) begin
            rv_prev = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                check("post_handshake_rsp_valid", 32'(rsp_valid), 32'd0);
                check("post_handshake_cmd_ready", 32'(cmd_ready), 32'd1);
            end
            hs_prev = 1'b0;
            if (rsp_valid) begin
                check("cmd_ready_during_resp", 32'(cmd_ready), 32'd0);
                if (!rv_prev) begin
                    if (rsp_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
                    else check("rsp_latency", 32'(cyc), 32'(rsp_q[0].first_cyc));
                    snap = {rsp_rdata, rsp_err, rsp_tmo};
                end else begin
                    check("rsp_stable", 32'({rsp_rdata, rsp_err, rsp_tmo}), 32'(snap));
                end
                if (rsp_ready && rsp_q.size() != 0) begin
                    e = rsp_q.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_tmo", 32'(rsp_tmo), 32'(e.tmo));
                    hs_prev = 1'b1;
                end
            end
            rv_prev = rsp_valid;
        end
    end

    task automatic test_stall();
        rdy_low = 1'b1;
        issue(mk(1'b0, 4'd3, 8'h00, 0, 8'h5A, 1'b0));
        fork
            issue(mk(1'b1, 4'd7, 8'h3E, 1, 8'h00, 1'b0));
            begin
                int g = 0;
                while (!rsp_valid && g < 50) begin
                    @(negedge PCLK);
                    g++;
                end
                repeat (5) @(negedge PCLK);
                check("stall_cmd_ready_low", 32'(cmd_ready), 32'd0);
                rdy_low = 1'b0;
            end
        join
    endtask

    task automatic test_reset_in_access();
        int g = 0;
        issue(mk(1'b0, 4'd5, 8'h00, 40, 8'h77, 1'b0));
        while (!(PSEL && PENABLE) && g < 50) begin
            @(negedge PCLK);
            g++;
        end
        check("rst_reached_access", 32'(PSEL && PENABLE), 32'd1);
        @(posedge PCLK);
        #1 PRESET = 1'b1;
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        bus_q.delete();
        rsp_q.delete();
        @(negedge PCLK);
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("reset_psel", 32'(PSEL), 32'd0);
        check("reset_penable", 32'(PENABLE), 32'd0);
        check("reset_pwrite", 32'(PWRITE), 32'd0);
        check("reset_paddr", 32'(PADDR), 32'd0);
        check("reset_pwdata", 32'(PWDATA), 32'd0);
        check("reset_rsp", 32'({rsp_valid, rsp_rdata, rsp_err, rsp_tmo}), 32'd0);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge PCLK);
        #1 PRESET = 1'b0;

        issue(mk(1'b1, 4'd2, 8'hA5, 0, 8'h00, 1'b0));
        issue(mk(1'b0, 4'd6, 8'h00, 3, 8'h3C, 1'b0));
        issue(mk(1'b0, 4'd9, 8'h00, 0, 8'hC3, 1'b1));
        issue(mk(1'b0, 4'd1, 8'h00, 20, 8'h99, 1'b0));
        issue(mk(1'b1, 4'd4, 8'h11, TMO - 1, 8'h00, 1'b1));
        issue(mk(1'b0, 4'd8, 8'h00, TMO, 8'h42, 1'b0));
        drain();

        test_stall();
        drain();

        for (int i = 0; i < 60; i++) begin
            txn_t t;
            t.wr     = 1'($urandom_range(0, 1));
            t.addr   = AW'($urandom);
            t.wdata  = DW'($urandom);
            t.prdata = DW'($urandom);
            t.slverr = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) t.waits = int'($urandom_range(TMO - 2, TMO + 2));
            else                           t.waits = int'($urandom_range(0, 4));
            issue(t);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge PCLK);
        end
        drain();

        test_reset_in_access();
        issue(mk(1'b0, 4'd10, 8'h00, 2, 8'h6D, 1'b0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
